// File: rtl/tl_rx_vc_read_scheduler.sv
// Round-robin read scheduler for the P / NP / CPL receive buffers: unloads one
// TLP at a time as a header beat followed by up to 32-DW data beats.
//
// Handshake: a beat transfers on a cycle where o_valid & i_ready are both 1.
// Once o_valid rises, o_sel/o_sop/o_eop/o_beat_dw are frozen until i_ready,
// and the buffer control pulses appear only in transfer cycles.
module tl_rx_vc_read_scheduler #(
    parameter int DW               = 32,
    parameter int HDR_BUFFER_WIDTH = 4 * DW,
    parameter int R_CTRL_BUS_WIDTH = 6,
    parameter int BEAT_DW          = 32,
    parameter int ENTRY_DW         = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [2:0]                  i_hdr_empty_flag,
    input  logic [HDR_BUFFER_WIDTH-1:0] i_p_hdr,
    input  logic [HDR_BUFFER_WIDTH-1:0] i_np_hdr,
    input  logic [HDR_BUFFER_WIDTH-1:0] i_cpl_hdr,
    input  logic                        i_np_block,
    input  logic                        i_ready,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_p_r_ctrl_bus,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_np_r_ctrl_bus,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_cpl_r_ctrl_bus,
    output logic [1:0]                  o_sel,
    output logic                        o_valid,
    output logic                        o_sop,
    output logic                        o_eop,
    output logic [5:0]                  o_beat_dw,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic [10:0] BEAT_MAX = 11'(BEAT_DW);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  rr_q, rr_d;
    logic [10:0] rem_q, rem_d;

    logic [2:0]                  eligible;
    logic [1:0]                  cand1, cand2, grant_idx;
    logic                        grant_found;
    logic [HDR_BUFFER_WIDTH-1:0] hdr_sel;
    logic                        has_data;
    logic [9:0]                  len_field;
    logic [10:0]                 len_dw;
    logic [5:0]                  data_beat;
    logic [6:0]                  beat_round;
    logic [2:0]                  inc_value;
    logic                        partial;
    logic                        accept;
    logic [R_CTRL_BUS_WIDTH-1:0] ctrl;
    logic                        unused_hdr_bits;

    function automatic logic [1:0] next_q(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    // Search starts just after the last granted queue; rr itself is tried last.
    assign eligible = ~i_hdr_empty_flag & {1'b1, ~i_np_block, 1'b1};
    assign cand1    = next_q(rr_q);
    assign cand2    = next_q(cand1);

    always_comb begin
        grant_found = 1'b1;
        grant_idx   = rr_q;
        if (eligible[cand1])      grant_idx = cand1;
        else if (eligible[cand2]) grant_idx = cand2;
        else if (eligible[rr_q])  grant_idx = rr_q;
        else                      grant_found = 1'b0;
    end

    always_comb begin
        case (grant_idx)
            2'd1:    hdr_sel = i_np_hdr;
            2'd2:    hdr_sel = i_cpl_hdr;
            default: hdr_sel = i_p_hdr;
        endcase
    end

    assign has_data  = hdr_sel[HDR_BUFFER_WIDTH-2];
    assign len_field = hdr_sel[HDR_BUFFER_WIDTH-23:HDR_BUFFER_WIDTH-32];
    assign len_dw    = (len_field == 10'd0) ? 11'd1024 : {1'b0, len_field};
    assign unused_hdr_bits = ^{hdr_sel[HDR_BUFFER_WIDTH-1],
                               hdr_sel[HDR_BUFFER_WIDTH-3:HDR_BUFFER_WIDTH-22],
                               hdr_sel[HDR_BUFFER_WIDTH-33:0]};

    // Data beat sizing: entries consumed rounds up, a short tail flags alignment.
    assign data_beat  = (rem_q > BEAT_MAX) ? 6'(BEAT_DW) : rem_q[5:0];
    assign beat_round = {1'b0, data_beat} + 7'(ENTRY_DW - 1);
    assign inc_value  = 3'(beat_round / 7'(ENTRY_DW));
    assign partial    = (data_beat % 6'(ENTRY_DW)) != 6'd0;

    assign accept = (state_q != S_IDLE) && i_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    sel_d   = grant_idx;
                    rr_d    = grant_idx;
                    rem_d   = has_data ? len_dw : 11'd0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (i_ready) state_d = (rem_q == 11'd0) ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (i_ready) begin
                    rem_d = rem_q - {5'd0, data_beat};
                    if (rem_q <= BEAT_MAX) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            rr_q    <= 2'd0;
            rem_q   <= 11'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
        end
    end

    // Pulses are suppressed during reset so a TLP cut short pops nothing more.
    always_comb begin
        ctrl = '0;
        if (accept && !i_rst) begin
            if (state_q == S_HDR) ctrl = {1'b1, 1'b0, 3'd0, 1'b0};
            else                  ctrl = {1'b0, 1'b1, inc_value, partial};
        end
    end

    assign o_p_r_ctrl_bus   = (sel_q == 2'd0) ? ctrl : '0;
    assign o_np_r_ctrl_bus  = (sel_q == 2'd1) ? ctrl : '0;
    assign o_cpl_r_ctrl_bus = (sel_q == 2'd2) ? ctrl : '0;

    assign o_sel       = sel_q;
    assign o_valid     = (state_q != S_IDLE);
    assign o_sop       = (state_q == S_HDR);
    assign o_eop       = ((state_q == S_HDR) && (rem_q == 11'd0)) ||
                         ((state_q == S_DATA) && (rem_q <= BEAT_MAX));
    assign o_beat_dw   = (state_q == S_DATA) ? data_beat : 6'd0;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_tl_rx_vc_read_scheduler.sv
// Bench for tl_rx_vc_read_scheduler: behavioural header buffers, per-channel
// expected-beat queues filled at load time and drained by a negedge monitor.
module tb_tl_rx_vc_read_scheduler;

    localparam int HW = 128;
    localparam int W  = 14;  // {sop, eop, beat_dw[5:0], ctrl[5:0]}

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [2:0]    i_hdr_empty_flag = 3'b111;
    logic [HW-1:0] i_p_hdr = '0, i_np_hdr = '0, i_cpl_hdr = '0;
    logic          i_np_block = 1'b0;
    logic          i_ready = 1'b0;
    logic [5:0]    o_p_r_ctrl_bus, o_np_r_ctrl_bus, o_cpl_r_ctrl_bus;
    logic [1:0]    o_sel;
    logic          o_valid, o_sop, o_eop;
    logic [5:0]    o_beat_dw;
    logic [1:0]    o_dbg_state;

    tl_rx_vc_read_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_hdr_empty_flag(i_hdr_empty_flag),
        .i_p_hdr(i_p_hdr), .i_np_hdr(i_np_hdr), .i_cpl_hdr(i_cpl_hdr),
        .i_np_block(i_np_block), .i_ready(i_ready),
        .o_p_r_ctrl_bus(o_p_r_ctrl_bus), .o_np_r_ctrl_bus(o_np_r_ctrl_bus),
        .o_cpl_r_ctrl_bus(o_cpl_r_ctrl_bus), .o_sel(o_sel), .o_valid(o_valid),
        .o_sop(o_sop), .o_eop(o_eop), .o_beat_dw(o_beat_dw),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- buffer model and scoreboard ----------------
    logic [HW-1:0] p_q[$], np_q[$], cpl_q[$];
    logic [W-1:0]  exp_p[$], exp_np[$], exp_cpl[$];
    logic [1:0]    grant_log[$];
    int            sop_cyc[$];
    int            errors = 0, checks = 0, beats = 0;

    task automatic refresh_bufs();
        i_hdr_empty_flag = {cpl_q.size() == 0, np_q.size() == 0, p_q.size() == 0};
        i_p_hdr   = (p_q.size()   != 0) ? p_q[0]   : '0;
        i_np_hdr  = (np_q.size()  != 0) ? np_q[0]  : '0;
        i_cpl_hdr = (cpl_q.size() != 0) ? cpl_q[0] : '0;
    endtask

    task automatic clear_all();
        p_q.delete(); np_q.delete(); cpl_q.delete();
        exp_p.delete(); exp_np.delete(); exp_cpl.delete();
        grant_log.delete(); sop_cyc.delete();
        refresh_bufs();
    endtask

    function automatic logic [HW-1:0] make_hdr(input logic has_data, input logic [9:0] len);
        logic [HW-1:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[HW-2] = has_data;
        h[HW-23:HW-32] = len;
        return h;
    endfunction

    task automatic push_exp(input int ch, input logic [W-1:0] v);
        case (ch)
            0: exp_p.push_back(v);
            1: exp_np.push_back(v);
            default: exp_cpl.push_back(v);
        endcase
    endtask

    // Loads one TLP into channel ch and queues the beats it must produce.
    task automatic load_tlp(input int ch, input logic has_data, input logic [9:0] len);
        logic [HW-1:0] h;
        int rem, b, val;
        logic al, e;
        h = make_hdr(has_data, len);
        case (ch)
            0: p_q.push_back(h);
            1: np_q.push_back(h);
            default: cpl_q.push_back(h);
        endcase
        push_exp(ch, {1'b1, !has_data, 6'd0, 6'b100000});
        if (has_data) begin
            rem = (len == 10'd0) ? 1024 : int'(len);
            while (rem > 0) begin
                b   = (rem > 32) ? 32 : rem;
                val = (b + 7) / 8;
                al  = (b % 8) != 0;
                e   = (rem <= 32);
                push_exp(ch, {1'b0, e, 6'(b), 1'b0, 1'b1, 3'(val), al});
                rem -= b;
            end
        end
        refresh_bufs();
    endtask

    logic [W-1:0] act, expv;
    logic [5:0]   sbus;
    logic         prev_hold = 1'b0;
    logic [10:0]  prev_out;

    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if ({o_valid, o_sel, o_sop, o_eop, o_beat_dw} !== prev_out) begin
                    errors++;
                    $display("FAIL hold_stable: got %h want %h", {o_valid, o_sel, o_sop, o_eop, o_beat_dw}, prev_out);
                end
            end
            prev_hold = o_valid && !i_ready;
            prev_out  = {o_valid, o_sel, o_sop, o_eop, o_beat_dw};
            checks++;
            if (o_sel === 2'd3) begin
                errors++;
                $display("FAIL sel_range: got 3");
            end
            case (o_sel)
                2'd1:    sbus = o_np_r_ctrl_bus;
                2'd2:    sbus = o_cpl_r_ctrl_bus;
                default: sbus = o_p_r_ctrl_bus;
            endcase
            checks++;
            if ((o_sel != 2'd0 && o_p_r_ctrl_bus !== 6'd0) ||
                (o_sel != 2'd1 && o_np_r_ctrl_bus !== 6'd0) ||
                (o_sel != 2'd2 && o_cpl_r_ctrl_bus !== 6'd0) ||
                (!(o_valid && i_ready) && sbus !== 6'd0)) begin
                errors++;
                $display("FAIL bus_quiet: p=%h np=%h cpl=%h sel=%0d valid=%b ready=%b",
                         o_p_r_ctrl_bus, o_np_r_ctrl_bus, o_cpl_r_ctrl_bus, o_sel, o_valid, i_ready);
            end
            if (o_valid && i_ready) begin
                act = {o_sop, o_eop, o_beat_dw, sbus};
                beats++;
                checks++;
                if ((o_sel == 2'd0 && exp_p.size() == 0) ||
                    (o_sel == 2'd1 && exp_np.size() == 0) ||
                    (o_sel == 2'd2 && exp_cpl.size() == 0)) begin
                    errors++;
                    $display("FAIL beat_unexpected: sel=%0d got %h want none", o_sel, act);
                end else begin
                    case (o_sel)
                        2'd1:    expv = exp_np.pop_front();
                        2'd2:    expv = exp_cpl.pop_front();
                        default: expv = exp_p.pop_front();
                    endcase
                    if (act !== expv) begin
                        errors++;
                        $display("FAIL beat sel=%0d: got %h want %h", o_sel, act, expv);
                    end
                end
                if (o_sop) begin
                    grant_log.push_back(o_sel);
                    sop_cyc.push_back(cyc);
                end
                if (sbus[5]) begin
                    case (o_sel)
                        2'd1:    if (np_q.size() != 0) void'(np_q.pop_front());
                        2'd2:    if (cpl_q.size() != 0) void'(cpl_q.pop_front());
                        default: if (p_q.size() != 0) void'(p_q.pop_front());
                    endcase
                    refresh_bufs();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        clear_all();
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, input bit toggle, input string name);
        int n = 0;
        while (n < max_cyc && !(exp_p.size() == 0 && exp_np.size() == 0 && exp_cpl.size() == 0 &&
                                p_q.size() == 0 && np_q.size() == 0 && cpl_q.size() == 0 && !o_valid)) begin
            @(posedge i_clk); #1;
            if (toggle) i_ready = 1'($urandom_range(0, 1));
            n++;
        end
        i_ready = 1'b1;
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL %s_drain: got timeout after %0d cycles want drained", name, n);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({o_valid, o_sop, o_eop, o_sel, o_beat_dw, o_dbg_state,
             o_p_r_ctrl_bus, o_np_r_ctrl_bus, o_cpl_r_ctrl_bus} !== '0) begin
            errors++;
            $display("FAIL %s: valid=%b sop=%b eop=%b sel=%0d beat=%0d st=%0d buses=%h/%h/%h want all 0",
                     name, o_valid, o_sop, o_eop, o_sel, o_beat_dw, o_dbg_state,
                     o_p_r_ctrl_bus, o_np_r_ctrl_bus, o_cpl_r_ctrl_bus);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_ready = 1'b0;
        do_reset();
        @(negedge i_clk);
        check_zero_outputs("reset_outputs");
        repeat (3) @(negedge i_clk);
        check_zero_outputs("reset_idle_empty");
    endtask

    task automatic test_single_posted();
        i_ready = 1'b1;
        beats = 0;
        @(posedge i_clk); #1;
        load_tlp(0, 1'b1, 10'd40);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: got valid=%b want 0", o_valid);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_sop !== 1'b1 || o_sel !== 2'd0) begin
            errors++; $display("FAIL latency_grant: got valid=%b sop=%b sel=%0d want 1 1 0", o_valid, o_sop, o_sel);
        end
        wait_drain(50, 1'b0, "single_posted");
        checks++;
        if (beats != 3) begin
            errors++; $display("FAIL single_posted_beats: got %0d want 3", beats);
        end
    endtask

    task automatic test_np_no_data();
        i_ready = 1'b1;
        beats = 0;
        @(posedge i_clk); #1;
        grant_log.delete(); sop_cyc.delete();
        load_tlp(1, 1'b0, 10'd1);
        load_tlp(1, 1'b0, 10'd1);
        wait_drain(50, 1'b0, "np_no_data");
        checks++;
        if (beats != 2) begin
            errors++; $display("FAIL np_no_data_beats: got %0d want 2", beats);
        end
        checks++;
        if (sop_cyc.size() != 2 || (sop_cyc[1] - sop_cyc[0]) != 2) begin
            errors++; $display("FAIL np_regrant_gap: got %0d grants want 2 grants 2 cycles apart", sop_cyc.size());
        end
        checks++;
        if (grant_log.size() != 2 || grant_log[0] !== 2'd1 || grant_log[1] !== 2'd1) begin
            errors++; $display("FAIL np_no_data_sel: got %0d grants want two NP grants", grant_log.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_order[6];
        exp_order = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        i_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_tlp(0, 1'b1, 10'd1);
            load_tlp(1, 1'b1, 10'd1);
            load_tlp(2, 1'b1, 10'd1);
        end
        wait_drain(100, 1'b0, "round_robin");
        checks++;
        if (grant_log.size() != 6) begin
            errors++; $display("FAIL rr_count: got %0d want 6", grant_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (grant_log[k] !== exp_order[k]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, grant_log[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_np_blocking();
        int n;
        do_reset();
        i_ready = 1'b1;
        i_np_block = 1'b1;
        load_tlp(0, 1'b1, 10'd4);
        load_tlp(1, 1'b0, 10'd1);
        load_tlp(0, 1'b0, 10'd1);
        n = 0;
        while (n < 100 && !(exp_p.size() == 0 && !o_valid)) begin
            @(posedge i_clk); #1;
            n++;
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || np_q.size() != 1 || grant_log.size() != 2 ||
            grant_log[0] !== 2'd0 || grant_log[1] !== 2'd0) begin
            errors++; $display("FAIL np_blocked: got valid=%b np_pending=%0d grants=%0d want 0 1 2(P only)",
                               o_valid, np_q.size(), grant_log.size());
        end
        @(posedge i_clk); #1;
        i_np_block = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_sel !== 2'd1 || o_sop !== 1'b1) begin
            errors++; $display("FAIL np_unblock_grant: got valid=%b sel=%0d sop=%b want 1 1 1", o_valid, o_sel, o_sop);
        end
        wait_drain(50, 1'b0, "np_blocking");
    endtask

    task automatic test_backpressure_reset();
        int n;
        do_reset();
        beats = 0;
        i_ready = 1'b0;
        load_tlp(0, 1'b1, 10'd0);
        wait_drain(2000, 1'b1, "backpressure");
        checks++;
        if (beats != 33) begin
            errors++; $display("FAIL len1024_beats: got %0d want 33 (1 hdr + 32 data)", beats);
        end
        i_ready = 1'b1;
        beats = 0;
        @(posedge i_clk); #1;
        load_tlp(2, 1'b1, 10'd0);
        n = 0;
        while (n < 20 && beats < 4) begin
            @(posedge i_clk); #1;
            n++;
        end
        i_rst = 1'b1;
        clear_all();
        @(negedge i_clk);
        checks++;
        if ({o_p_r_ctrl_bus, o_np_r_ctrl_bus, o_cpl_r_ctrl_bus} !== '0) begin
            errors++; $display("FAIL reset_no_pulse: got buses %h/%h/%h want 0",
                               o_p_r_ctrl_bus, o_np_r_ctrl_bus, o_cpl_r_ctrl_bus);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_zero_outputs("reset_mid_tlp");
    endtask

    initial begin
        test_reset();
        test_single_posted();
        test_np_no_data();
        test_round_robin();
        test_np_blocking();
        test_backpressure_reset();
        repeat (2) @(posedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
